core_bus_interface: RTL and testbench

- Per-core request stage directly upstream of bus_controller; one instance per core.
- Buffers L1 miss/upgrade requests in a small FIFO and drives req_core/bus_operation/bus_address/opcode toward bus_controller.
- Holds each request until granted, then classifies the same-cycle response (peer hit, L2 hit, L2 miss).
- Returns a registered fill to L1; retries on L2 miss and reports an error after a bounded number of retries.

---
 rtl/bus_pkg.sv | 31 +++
 rtl/core_bus_interface_if.sv | 40 ++++
 rtl/req_fifo.sv | 55 +++++
 rtl/core_bus_interface.sv | 158 +++++++++++++++
 tb/tb_core_bus_interface.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// Shared types for the per-core request stage feeding bus_controller.
// Holds the bus opcode enum, L2 response codes, the request payload and FSM states.
package bus_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned OPC_W  = 7;

   typedef enum logic [1:0] {
      BUS_RD   = 2'b00,
      BUS_UPGR = 2'b01,
      BUS_RDX  = 2'b10,
      BUS_NON  = 2'b11
   } bus_op_t;

   localparam logic [1:0] L2_HIT  = 2'b10;
   localparam logic [1:0] L2_MISS = 2'b01;

   typedef struct packed {
      bus_op_t           op;
      logic [ADDR_W-1:0] addr;
      logic [OPC_W-1:0]  opcode;
   } bus_req_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_RETRY = 2'd2
   } cbi_state_t;

endpackage

// File: rtl/core_bus_interface_if.sv
// L1-side request handshake plus bus_controller request/response signals.
// master = the request stage, slave = the surrounding L1/bus_controller.
interface core_bus_interface_if;

   logic                        miss_valid;
   logic                        miss_ready;
   logic [1:0]                  miss_op;
   logic [bus_pkg::ADDR_W-1:0]  miss_addr;
   logic [bus_pkg::OPC_W-1:0]   miss_opcode;
   logic                        req_core;
   logic                        grant_core;
   logic [1:0]                  bus_operation_out;
   logic [bus_pkg::ADDR_W-1:0]  bus_address_out;
   logic [bus_pkg::OPC_W-1:0]   opcode_out;
   logic [bus_pkg::DATA_W-1:0]  bus_data_in;
   logic                        cache_hit_in;
   logic [1:0]                  cache_hit_L2;
   logic                        flush;
   logic                        fill_valid;
   logic [bus_pkg::DATA_W-1:0]  fill_data;
   logic                        fill_src;
   logic                        upgr_done;
   logic                        err_pulse;
   logic                        busy;

   modport master (
      input  miss_valid, miss_op, miss_addr, miss_opcode, grant_core,
             bus_data_in, cache_hit_in, cache_hit_L2, flush,
      output miss_ready, req_core, bus_operation_out, bus_address_out, opcode_out,
             fill_valid, fill_data, fill_src, upgr_done, err_pulse, busy
   );

   modport slave (
      output miss_valid, miss_op, miss_addr, miss_opcode, grant_core,
             bus_data_in, cache_hit_in, cache_hit_L2, flush,
      input  miss_ready, req_core, bus_operation_out, bus_address_out, opcode_out,
             fill_valid, fill_data, fill_src, upgr_done, err_pulse, busy
   );

endinterface

// File: rtl/req_fifo.sv
// Synchronous request FIFO; DEPTH must be a power of two so pointers wrap naturally.
module req_fifo
   import bus_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   flush,
   input  logic                   push,
   input  logic                   pop,
   input  bus_req_t               wdata,
   output bus_req_t               rdata,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = PTR_W + 1;

   bus_req_t         mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             wr_en;
   logic             rd_en;

   assign wr_en = push && !full;
   assign rd_en = pop && !empty;
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);
   assign rdata = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
         if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Storage needs no reset: entries are only read while counted valid.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/core_bus_interface.sv
// Per-core request stage: queues L1 misses, requests the bus, classifies the
// granted response and returns a registered fill, upgrade ack or error.
module core_bus_interface
   import bus_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 2,
   parameter int unsigned RETRY_DELAY = 4,
   parameter int unsigned MAX_RETRY   = 3
) (
   input logic                  clk,
   input logic                  reset,
   core_bus_interface_if.master bif
);

   localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH) + 1;
   localparam int unsigned RTRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned DLY_W  = (RETRY_DELAY > 0) ? $clog2(RETRY_DELAY + 1) : 1;

   cbi_state_t        state;
   cbi_state_t        state_nxt;
   bus_req_t          head;
   bus_req_t          wreq;
   logic              full;
   logic              empty;
   logic              push;
   logic              pop;
   logic [CNT_W-1:0]  count;
   logic [RTRY_W-1:0] retry_cnt;
   logic [RTRY_W-1:0] retry_cnt_nxt;
   logic [DLY_W-1:0]  dly_cnt;
   logic [DLY_W-1:0]  dly_cnt_nxt;
   logic              fill_valid_nxt;
   logic              fill_src_nxt;
   logic [DATA_W-1:0] fill_data_nxt;
   logic              upgr_done_nxt;
   logic              err_pulse_nxt;
   logic              granted;
   logic              serviced;
   logic              out_of_retries;

   assign wreq           = '{op: bus_op_t'(bif.miss_op), addr: bif.miss_addr, opcode: bif.miss_opcode};
   assign push           = bif.miss_valid && bif.miss_ready && (wreq.op != BUS_NON) && !bif.flush;
   assign granted        = (state == ST_REQ) && bif.grant_core;
   assign serviced       = (head.op == BUS_UPGR) || bif.cache_hit_in || (bif.cache_hit_L2 == L2_HIT);
   assign out_of_retries = (retry_cnt == RTRY_W'(MAX_RETRY));
   assign pop            = granted && (serviced || out_of_retries) && !bif.flush;

   assign bif.miss_ready = !full;
   assign bif.busy       = (count != '0) || (state != ST_IDLE);

   req_fifo #(.DEPTH(FIFO_DEPTH)) u_req_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (bif.flush),
      .push  (push),
      .pop   (pop),
      .wdata (wreq),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   always_ff @(posedge clk) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // A push this cycle is enough to leave IDLE; the head is read from storage next cycle.
   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:  if (!empty || push) state_nxt = ST_REQ;
         ST_REQ: begin
            if (granted) begin
               if (!serviced && !out_of_retries) state_nxt = ST_RETRY;
               else                              state_nxt = ST_IDLE;
            end
         end
         ST_RETRY: if (dly_cnt <= DLY_W'(1)) state_nxt = ST_REQ;
         default:  state_nxt = ST_IDLE;
      endcase
      if (bif.flush) state_nxt = ST_IDLE;
   end

   always_comb begin
      retry_cnt_nxt         = retry_cnt;
      dly_cnt_nxt           = dly_cnt;
      fill_valid_nxt        = 1'b0;
      fill_src_nxt          = bif.fill_src;
      fill_data_nxt         = bif.fill_data;
      upgr_done_nxt         = 1'b0;
      err_pulse_nxt         = 1'b0;
      bif.req_core          = (state == ST_REQ);
      bif.bus_operation_out = BUS_NON;
      bif.bus_address_out   = '0;
      bif.opcode_out        = '0;
      case (state)
         ST_REQ: begin
            bif.bus_operation_out = head.op;
            bif.bus_address_out   = head.addr;
            bif.opcode_out        = head.opcode;
            if (granted) begin
               if (head.op == BUS_UPGR) begin
                  upgr_done_nxt = 1'b1;
               end else if (bif.cache_hit_in) begin
                  fill_valid_nxt = 1'b1;
                  fill_src_nxt   = 1'b1;
                  fill_data_nxt  = bif.bus_data_in;
               end else if (bif.cache_hit_L2 == L2_HIT) begin
                  fill_valid_nxt = 1'b1;
                  fill_src_nxt   = 1'b0;
                  fill_data_nxt  = bif.bus_data_in;
               end else if (out_of_retries) begin
                  err_pulse_nxt = 1'b1;
               end else begin
                  retry_cnt_nxt = retry_cnt + RTRY_W'(1);
                  dly_cnt_nxt   = DLY_W'(RETRY_DELAY);
               end
               if (pop) retry_cnt_nxt = '0;
            end
         end
         ST_RETRY: if (dly_cnt != '0) dly_cnt_nxt = dly_cnt - DLY_W'(1);
         default: ;
      endcase
      // Aborted requests produce no completion of any kind.
      if (bif.flush) begin
         retry_cnt_nxt  = '0;
         dly_cnt_nxt    = '0;
         fill_valid_nxt = 1'b0;
         fill_src_nxt   = bif.fill_src;
         fill_data_nxt  = bif.fill_data;
         upgr_done_nxt  = 1'b0;
         err_pulse_nxt  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         retry_cnt      <= '0;
         dly_cnt        <= '0;
         bif.fill_valid <= 1'b0;
         bif.fill_src   <= 1'b0;
         bif.fill_data  <= '0;
         bif.upgr_done  <= 1'b0;
         bif.err_pulse  <= 1'b0;
      end else begin
         retry_cnt      <= retry_cnt_nxt;
         dly_cnt        <= dly_cnt_nxt;
         bif.fill_valid <= fill_valid_nxt;
         bif.fill_src   <= fill_src_nxt;
         bif.fill_data  <= fill_data_nxt;
         bif.upgr_done  <= upgr_done_nxt;
         bif.err_pulse  <= err_pulse_nxt;
      end
   end

endmodule

// File: tb/tb_core_bus_interface.sv
// Bench for core_bus_interface: a scripted bus_controller responder, a
// completion scoreboard fed at issue time, directed scenarios and random traffic.
module tb_core_bus_interface;
   import bus_pkg::*;

   localparam int unsigned RETRY_DELAY = 4;
   localparam int unsigned MAX_RETRY   = 3;

   logic clk = 1'b0;
   logic reset = 1'b1;

   core_bus_interface_if bif();

   core_bus_interface #(
      .FIFO_DEPTH  (2),
      .RETRY_DELAY (RETRY_DELAY),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bif   (bif)
   );

   always #5 clk = ~clk;

   // Per-request script: grant withheld 'hold' request cycles per attempt,
   // 'misses' L2-miss answers before the final hit.
   typedef struct {
      logic [1:0]  op;
      logic [31:0] addr;
      logic [6:0]  opcode;
      int          hold;
      int          misses;
      bit          peer;
      logic [31:0] data;
   } plan_t;

   // kind: 0 fill, 1 upgrade done, 2 error
   typedef struct {
      int          kind;
      logic [31:0] data;
      bit          src;
   } exp_t;

   plan_t plan_q[$];
   exp_t  exp_q[$];
   int    n_chk = 0;
   int    n_pass = 0;
   int    cyc = 0;
   int    last_grant_cyc = -100;
   int    last_evt_cyc = -100;
   int    last_miss_cyc = 0;
   int    push_cyc = 0;
   int    attempt = 0;
   int    hold_cnt = 0;
   bit    pending_retry = 1'b0;
   bit    prev_req = 1'b0;
   bit    resp_reset = 1'b0;
   plan_t resp_p;
   exp_t  mon_e;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, got, want, cyc);
   endtask

   task automatic fail(input string name, input logic [31:0] got, input logic [31:0] want);
      n_chk++;
      $display("FAIL %s: got 0x%0h want 0x%0h at cycle %0d", name, got, want, cyc);
   endtask

   // Outcome of a request follows only from its op and how many misses it sees.
   function automatic exp_t predict(input plan_t p);
      exp_t e;
      e.data = '0;
      e.src  = 1'b0;
      if (p.op == 2'b01)               e.kind = 1;
      else if (p.misses > MAX_RETRY)   e.kind = 2;
      else begin
         e.kind = 0;
         e.data = p.data;
         e.src  = p.peer;
      end
      return e;
   endfunction

   always @(posedge clk) cyc <= cyc + 1;

   // bus_controller stand-in: checks the presented request, answers per script.
   always @(posedge clk) begin
      #1;
      if (resp_reset) begin
         attempt       = 0;
         hold_cnt      = 0;
         pending_retry = 1'b0;
         resp_reset    = 1'b0;
      end
      bif.grant_core   = 1'b0;
      bif.bus_data_in  = $urandom;
      bif.cache_hit_in = 1'($urandom_range(0, 1));
      bif.cache_hit_L2 = 2'($urandom_range(0, 3));
      if (bif.req_core) begin
         if (plan_q.size() == 0) begin
            fail("unexpected_req", 32'(bif.bus_address_out), 0);
         end else begin
            resp_p = plan_q[0];
            chk("req_op", 32'(bif.bus_operation_out), 32'(resp_p.op));
            chk("req_addr", bif.bus_address_out, resp_p.addr);
            chk("req_opcode", 32'(bif.opcode_out), 32'(resp_p.opcode));
            if (!prev_req && pending_retry) begin
               chk("retry_gap", 32'(cyc - last_miss_cyc), 32'(RETRY_DELAY + 1));
               pending_retry = 1'b0;
            end
            if (hold_cnt >= resp_p.hold) begin
               bif.grant_core = 1'b1;
               hold_cnt       = 0;
               last_grant_cyc = cyc;
               if (resp_p.op != 2'b01 && attempt < resp_p.misses) begin
                  bif.cache_hit_in = 1'b0;
                  bif.cache_hit_L2 = ($urandom_range(0, 3) == 0) ? 2'b00 : 2'b01;
                  attempt++;
                  if (attempt > MAX_RETRY) begin
                     void'(plan_q.pop_front());
                     attempt = 0;
                  end else begin
                     pending_retry = 1'b1;
                     last_miss_cyc = cyc;
                  end
               end else begin
                  if (resp_p.op != 2'b01) begin
                     if (resp_p.peer) begin
                        bif.cache_hit_in = 1'b1;
                     end else begin
                        bif.cache_hit_in = 1'b0;
                        bif.cache_hit_L2 = 2'b10;
                     end
                     bif.bus_data_in = resp_p.data;
                  end
                  void'(plan_q.pop_front());
                  attempt = 0;
               end
            end else begin
               hold_cnt++;
            end
         end
      end else begin
         chk("idle_op", 32'(bif.bus_operation_out), 32'h3);
         chk("idle_addr", bif.bus_address_out, 0);
         chk("idle_opcode", 32'(bif.opcode_out), 0);
      end
      prev_req = bif.req_core;
   end

   // Completion monitor: pops the scoreboard on every pulse.
   always @(posedge clk) begin
      #1;
      if (bif.fill_valid || bif.upgr_done || bif.err_pulse) begin
         last_evt_cyc = cyc;
         chk("one_pulse", 32'(bif.fill_valid) + 32'(bif.upgr_done) + 32'(bif.err_pulse), 1);
         if (exp_q.size() == 0) begin
            fail("unexpected_pulse", {29'd0, bif.fill_valid, bif.upgr_done, bif.err_pulse}, 0);
         end else begin
            mon_e = exp_q.pop_front();
            chk("evt_kind", bif.fill_valid ? 0 : (bif.upgr_done ? 1 : 2), 32'(mon_e.kind));
            if (mon_e.kind == 0) begin
               chk("fill_data", bif.fill_data, mon_e.data);
               chk("fill_src", 32'(bif.fill_src), 32'(mon_e.src));
            end
            chk("evt_latency", 32'(cyc), 32'(last_grant_cyc + 1));
         end
      end
   end

   // Called at a negedge; returns at the following negedge with miss_valid low.
   task automatic drive_req(input logic [1:0] op, input logic [31:0] addr, input logic [6:0] opcode,
                            input int hold, input int misses, input bit peer, input logic [31:0] data);
      plan_t p;
      int    waited;
      waited   = 0;
      p.op     = op;
      p.addr   = addr;
      p.opcode = opcode;
      p.hold   = hold;
      p.misses = (op == 2'b01) ? 0 : misses;
      p.peer   = peer;
      p.data   = data;
      while (!bif.miss_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bif.miss_ready) begin
         fail("ready_timeout", 0, 1);
         return;
      end
      bif.miss_valid  = 1'b1;
      bif.miss_op     = op;
      bif.miss_addr   = addr;
      bif.miss_opcode = opcode;
      plan_q.push_back(p);
      exp_q.push_back(predict(p));
      push_cyc = cyc;
      @(negedge clk);
      bif.miss_valid = 1'b0;
   endtask

   task automatic wait_idle(input int max_cyc);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || bif.busy) && n < max_cyc) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0 || bif.busy) fail("drain_timeout", 32'(exp_q.size()), 0);
   endtask

   task automatic abort_queues();
      plan_q.delete();
      exp_q.delete();
      resp_reset = 1'b1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p0;
      int r;
      logic [1:0] op;
      int misses;

      bif.miss_valid   = 1'b0;
      bif.miss_op      = 2'b00;
      bif.miss_addr    = '0;
      bif.miss_opcode  = '0;
      bif.grant_core   = 1'b0;
      bif.bus_data_in  = '0;
      bif.cache_hit_in = 1'b0;
      bif.cache_hit_L2 = 2'b00;
      bif.flush        = 1'b0;
      reset            = 1'b1;
      repeat (3) @(negedge clk);

      chk("rst_miss_ready", 32'(bif.miss_ready), 1);
      chk("rst_req_core", 32'(bif.req_core), 0);
      chk("rst_bus_op", 32'(bif.bus_operation_out), 32'h3);
      chk("rst_bus_addr", bif.bus_address_out, 0);
      chk("rst_opcode", 32'(bif.opcode_out), 0);
      chk("rst_fill_valid", 32'(bif.fill_valid), 0);
      chk("rst_fill_data", bif.fill_data, 0);
      chk("rst_fill_src", 32'(bif.fill_src), 0);
      chk("rst_upgr_done", 32'(bif.upgr_done), 0);
      chk("rst_err_pulse", 32'(bif.err_pulse), 0);
      chk("rst_busy", 32'(bif.busy), 0);
      reset = 1'b0;
      @(negedge clk);

      // Best-case L2 hit
      drive_req(2'b00, 32'h100, 7'h03, 0, 0, 1'b0, 32'hDEAD_BEEF);
      p0 = push_cyc;
      wait_idle(50);
      chk("t1_latency", 32'(last_evt_cyc), 32'(p0 + 2));

      // Grant withheld three cycles, peer hit
      drive_req(2'b10, 32'h200, 7'h23, 3, 0, 1'b1, 32'h1234_5678);
      p0 = push_cyc;
      wait_idle(50);
      chk("t2_latency", 32'(last_evt_cyc), 32'(p0 + 5));

      // Upgrade
      drive_req(2'b01, 32'h300, 7'h33, 0, 0, 1'b0, 32'h0);
      p0 = push_cyc;
      wait_idle(50);
      chk("t3_latency", 32'(last_evt_cyc), 32'(p0 + 2));

      // Persistent L2 miss exhausts retries
      drive_req(2'b00, 32'h400, 7'h13, 0, MAX_RETRY + 1, 1'b0, 32'h0);
      p0 = push_cyc;
      wait_idle(100);
      chk("t4_err_time", 32'(last_evt_cyc), 32'(p0 + 1 + int'(MAX_RETRY) * int'(RETRY_DELAY + 1) + 1));

      // Three back-to-back into a depth-2 FIFO
      drive_req(2'b00, 32'h500, 7'h01, 3, 0, 1'b0, 32'hAAAA_0001);
      drive_req(2'b10, 32'h504, 7'h02, 0, 0, 1'b1, 32'hAAAA_0002);
      chk("t5_full", 32'(bif.miss_ready), 0);
      drive_req(2'b00, 32'h508, 7'h04, 0, 0, 1'b0, 32'hAAAA_0003);
      wait_idle(100);

      // Flush while retrying with one queued, plus a push in the flush cycle
      drive_req(2'b00, 32'h600, 7'h05, 0, 1, 1'b0, 32'hBBBB_0001);
      drive_req(2'b10, 32'h604, 7'h06, 0, 0, 1'b1, 32'hBBBB_0002);
      bif.flush       = 1'b1;
      bif.miss_valid  = 1'b1;
      bif.miss_op     = 2'b00;
      bif.miss_addr   = 32'h700;
      bif.miss_opcode = 7'h07;
      abort_queues();
      @(negedge clk);
      bif.flush      = 1'b0;
      bif.miss_valid = 1'b0;
      chk("t6_busy", 32'(bif.busy), 0);
      chk("t6_req_core", 32'(bif.req_core), 0);
      chk("t6_miss_ready", 32'(bif.miss_ready), 1);
      repeat (10) @(negedge clk);
      drive_req(2'b00, 32'h800, 7'h08, 0, 0, 1'b0, 32'hCAFE_F00D);
      p0 = push_cyc;
      wait_idle(50);
      chk("t6_after_flush", 32'(last_evt_cyc), 32'(p0 + 2));

      // Reset in the middle of a request
      drive_req(2'b10, 32'h900, 7'h09, 6, 0, 1'b0, 32'h0);
      reset = 1'b1;
      abort_queues();
      @(negedge clk);
      chk("t7_req_core", 32'(bif.req_core), 0);
      chk("t7_busy", 32'(bif.busy), 0);
      chk("t7_bus_op", 32'(bif.bus_operation_out), 32'h3);
      chk("t7_fill_data", bif.fill_data, 0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // Random traffic
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         if ($urandom_range(0, 4) == 0) begin
            bif.miss_valid = 1'b1;
            bif.miss_op    = 2'b11;
            bif.miss_addr  = $urandom;
            @(negedge clk);
            bif.miss_valid = 1'b0;
         end
         r  = int'($urandom_range(0, 2));
         op = 2'(r);
         r  = int'($urandom_range(0, 7));
         misses = (r < 4) ? 0 : r - 3;
         drive_req(op, $urandom, 7'($urandom), int'($urandom_range(0, 2)), misses,
                   1'($urandom_range(0, 1)), $urandom);
      end
      wait_idle(3000);

      chk("end_miss_ready", 32'(bif.miss_ready), 1);
      chk("end_req_core", 32'(bif.req_core), 0);
      chk("end_plan_empty", 32'(plan_q.size()), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
